// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator: opcodes, FSM states,
// next-IP select encoding and the control-op classifier.
package pc_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {
        RUN,
        WAIT
    } pc_state_t;

    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_INC4,
        SEL_TARGET,
        SEL_FLUSH
    } ip_sel_t;

    function automatic logic is_ctrl(input logic [6:0] op);
        return (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/pc_redirect_fsm.sv
// Fetch/redirect controller: RUN/WAIT state, wait counter, timeout detection
// and the next-IP select consumed by the IP register in pc_gen.
module pc_redirect_fsm
    import pc_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [6:0] op,
    input  logic       fetch_ready,
    input  logic       stall,
    input  logic       resolve_vld,
    input  logic       b_taken,
    input  logic       flush,
    output ip_sel_t    ip_sel,
    output logic       fetch_vld,
    output logic       bubble,
    output logic       timeout
);

    localparam int unsigned WCNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    pc_state_t         state_q, state_n;
    logic [WCNT_W-1:0] wcnt_q, wcnt_n;
    logic [6:0]        op_q, op_n;

    // State, wait counter and latched control opcode
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= RUN;
            wcnt_q  <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_n;
            wcnt_q  <= wcnt_n;
            op_q    <= op_n;
        end
    end

    // Next state and IP select; priority flush > stall > FSM, all gated by RESET
    always_comb begin
        state_n   = state_q;
        wcnt_n    = wcnt_q;
        op_n      = op_q;
        ip_sel    = SEL_HOLD;
        fetch_vld = 1'b0;
        bubble    = 1'b0;
        timeout   = 1'b0;
        if (RESET) begin
            ip_sel = SEL_HOLD;
        end else if (flush) begin
            ip_sel  = SEL_FLUSH;
            state_n = RUN;
            wcnt_n  = '0;
        end else if (!stall) begin
            case (state_q)
                RUN: begin
                    fetch_vld = 1'b1;
                    if (fetch_ready) begin
                        if (is_ctrl(op)) begin
                            state_n = WAIT;
                            wcnt_n  = '0;
                            op_n    = op;
                        end else begin
                            ip_sel = SEL_INC4;
                        end
                    end
                end
                WAIT: begin
                    bubble = 1'b1;
                    wcnt_n = wcnt_q + WCNT_W'(1);
                    if (resolve_vld) begin
                        state_n = RUN;
                        wcnt_n  = '0;
                        ip_sel  = ((op_q != OP_BRANCH) || b_taken) ? SEL_TARGET : SEL_INC4;
                    end else if (wcnt_q == WCNT_W'(MAX_WAIT - 1)) begin
                        state_n = RUN;
                        wcnt_n  = '0;
                        timeout = 1'b1;
                        ip_sel  = SEL_INC4;
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: IP register, next-IP mux, alignment checks and
// saturating bubble counter around the redirect FSM.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_VEC = '0,
    parameter int unsigned      MAX_WAIT  = 4,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [6:0]       op,
    input  logic             fetch_ready,
    input  logic             stall,
    input  logic             resolve_vld,
    input  logic             b_taken,
    input  logic [XLEN-1:0]  target,
    input  logic             flush,
    input  logic [XLEN-1:0]  flush_tgt,
    output logic [XLEN-1:0]  IP,
    output logic [XLEN-1:0]  PC_def,
    output logic             fetch_vld,
    output logic             misalign,
    output logic             timeout,
    output logic [CNT_W-1:0] bubble_cnt
);

    ip_sel_t         ip_sel;
    logic            bubble;
    logic [XLEN-1:0] ip_q, ip_n;
    logic [CNT_W-1:0] bcnt_q;

    pc_redirect_fsm #(
        .MAX_WAIT (MAX_WAIT)
    ) u_fsm (
        .CLK         (CLK),
        .RESET       (RESET),
        .op          (op),
        .fetch_ready (fetch_ready),
        .stall       (stall),
        .resolve_vld (resolve_vld),
        .b_taken     (b_taken),
        .flush       (flush),
        .ip_sel      (ip_sel),
        .fetch_vld   (fetch_vld),
        .bubble      (bubble),
        .timeout     (timeout)
    );

    // Next-IP mux; redirect targets are forced to word alignment
    always_comb begin
        ip_n = ip_q;
        case (ip_sel)
            SEL_INC4:   ip_n = ip_q + XLEN'(4);
            SEL_TARGET: ip_n = {target[XLEN-1:2], 2'b00};
            SEL_FLUSH:  ip_n = {flush_tgt[XLEN-1:2], 2'b00};
            default:    ip_n = ip_q;
        endcase
    end

    // IP register
    always_ff @(posedge CLK) begin
        if (RESET) ip_q <= RESET_VEC;
        else       ip_q <= ip_n;
    end

    // Bubble counter, saturating at all-ones
    always_ff @(posedge CLK) begin
        if (RESET)                     bcnt_q <= '0;
        else if (bubble && bcnt_q != '1) bcnt_q <= bcnt_q + CNT_W'(1);
    end

    // Misalign pulses in the cycle a misaligned redirect is taken
    always_comb begin
        misalign = 1'b0;
        if (ip_sel == SEL_FLUSH)  misalign = (flush_tgt[1:0] != 2'b00);
        if (ip_sel == SEL_TARGET) misalign = (target[1:0] != 2'b00);
    end

    assign IP         = ip_q;
    assign PC_def     = ip_q + XLEN'(4);
    assign bubble_cnt = bcnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (RESET_VEC=0x100, MAX_WAIT=4).
module tb_pc_gen;
    import pc_pkg::*;

    localparam logic [6:0] NOP = 7'b0010011;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [6:0]  op;
    logic        fetch_ready, stall, resolve_vld, b_taken, flush;
    logic [31:0] target, flush_tgt;
    logic [31:0] IP, PC_def;
    logic        fetch_vld, misalign, timeout;
    logic [15:0] bubble_cnt;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 CLK = ~CLK;

    pc_gen #(
        .XLEN      (32),
        .RESET_VEC (32'h100),
        .MAX_WAIT  (4),
        .CNT_W     (16)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .op          (op),
        .fetch_ready (fetch_ready),
        .stall       (stall),
        .resolve_vld (resolve_vld),
        .b_taken     (b_taken),
        .target      (target),
        .flush       (flush),
        .flush_tgt   (flush_tgt),
        .IP          (IP),
        .PC_def      (PC_def),
        .fetch_vld   (fetch_vld),
        .misalign    (misalign),
        .timeout     (timeout),
        .bubble_cnt  (bubble_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1; op = NOP; fetch_ready = 1'b1; stall = 1'b0;
        resolve_vld = 1'b0; b_taken = 1'b0; target = '0; flush = 1'b0; flush_tgt = '0;

        // reset state
        tick();
        chk("rst_ip", IP, 32'h100);
        chk("rst_fvld", {31'b0, fetch_vld}, 0);
        chk("rst_mis", {31'b0, misalign}, 0);
        chk("rst_tmo", {31'b0, timeout}, 0);
        chk("rst_bcnt", {16'b0, bubble_cnt}, 0);
        RESET = 1'b0;
        #1;
        chk("run_fvld", {31'b0, fetch_vld}, 1);
        chk("pcdef0", PC_def, 32'h104);

        // straight-line fetch
        tick(); chk("seq_ip1", IP, 32'h104);
        tick(); chk("seq_ip2", IP, 32'h108);
        chk("pcdef2", PC_def, 32'h10C);

        // taken branch resolved in the 2nd WAIT cycle
        op = OP_BRANCH;
        tick(); chk("br_hold", IP, 32'h108);
        chk("br_bubble", {31'b0, fetch_vld}, 0);
        op = NOP;
        tick(); chk("br_hold2", IP, 32'h108);
        resolve_vld = 1'b1; b_taken = 1'b1; target = 32'h200;
        #1; chk("br_mis0", {31'b0, misalign}, 0);
        tick(); chk("br_tgt", IP, 32'h200);
        chk("br_bcnt", {16'b0, bubble_cnt}, 2);
        resolve_vld = 1'b0; b_taken = 1'b0;
        #1; chk("br_run", {31'b0, fetch_vld}, 1);

        // not-taken branch
        op = OP_BRANCH;
        tick(); op = NOP; resolve_vld = 1'b1; b_taken = 1'b0; target = 32'h300;
        tick(); chk("nt_ip", IP, 32'h204);
        chk("nt_bcnt", {16'b0, bubble_cnt}, 3);
        resolve_vld = 1'b0;

        // JAL never resolved: timeout in the 4th WAIT cycle
        op = OP_JAL;
        tick(); op = NOP;
        tick();
        tick(); #1; chk("tmo_early", {31'b0, timeout}, 0);
        tick(); chk("tmo_pulse", {31'b0, timeout}, 1);
        chk("tmo_fvld", {31'b0, fetch_vld}, 0);
        tick(); chk("tmo_ip", IP, 32'h208);
        chk("tmo_clr", {31'b0, timeout}, 0);
        chk("tmo_bcnt", {16'b0, bubble_cnt}, 7);

        // JALR to misaligned target
        op = OP_JALR;
        tick(); op = NOP; resolve_vld = 1'b1; target = 32'h402;
        #1; chk("jr_mis", {31'b0, misalign}, 1);
        tick(); chk("jr_ip", IP, 32'h400);
        resolve_vld = 1'b0;
        #1; chk("jr_mis_clr", {31'b0, misalign}, 0);

        // flush beats stall and resolve in the same cycle
        op = OP_BRANCH;
        tick(); op = NOP;
        flush = 1'b1; flush_tgt = 32'h3FE; stall = 1'b1; resolve_vld = 1'b1; b_taken = 1'b1; target = 32'h500;
        #1; chk("fl_mis", {31'b0, misalign}, 1);
        tick(); chk("fl_ip", IP, 32'h3FC);
        flush = 1'b0; stall = 1'b0; resolve_vld = 1'b0; b_taken = 1'b0;
        #1; chk("fl_mis_clr", {31'b0, misalign}, 0);
        chk("fl_run", {31'b0, fetch_vld}, 1);
        chk("fl_bcnt", {16'b0, bubble_cnt}, 8);

        // stall held 3 cycles mid-WAIT freezes IP, bubble count and wait counter
        op = OP_BRANCH;
        tick(); op = NOP;
        tick(); chk("st_bcnt0", {16'b0, bubble_cnt}, 9);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_ip", IP, 32'h3FC);
            chk("st_bcnt", {16'b0, bubble_cnt}, 9);
            chk("st_tmo", {31'b0, timeout}, 0);
        end
        stall = 1'b0;
        tick(); tick();
        chk("st_bcnt2", {16'b0, bubble_cnt}, 11);
        chk("st_tmo_late", {31'b0, timeout}, 1);
        tick(); chk("st_ip_out", IP, 32'h400);
        chk("st_bcnt3", {16'b0, bubble_cnt}, 12);

        // wrap-around past the top of the address space
        flush = 1'b1; flush_tgt = 32'hFFFF_FFFC;
        #1; chk("wr_mis0", {31'b0, misalign}, 0);
        tick(); flush = 1'b0;
        chk("wr_ip", IP, 32'hFFFF_FFFC);
        chk("wr_pcdef", PC_def, 32'h0);
        tick(); chk("wr_ip0", IP, 32'h0);

        // resolve outside WAIT ignored; fetch_ready low holds IP
        fetch_ready = 1'b0; resolve_vld = 1'b1; target = 32'h700;
        tick(); chk("rv_ign", IP, 32'h0);
        resolve_vld = 1'b0; fetch_ready = 1'b1;

        // RESET in the middle of WAIT: back to RESET_VEC, no pulses
        op = OP_JAL;
        tick(); op = NOP;
        RESET = 1'b1; resolve_vld = 1'b1; target = 32'h6;
        #1; chk("rw_mis", {31'b0, misalign}, 0);
        chk("rw_tmo", {31'b0, timeout}, 0);
        chk("rw_fvld", {31'b0, fetch_vld}, 0);
        tick(); chk("rw_ip", IP, 32'h100);
        chk("rw_bcnt", {16'b0, bubble_cnt}, 0);
        RESET = 1'b0; resolve_vld = 1'b0;
        #1; chk("rw_run", {31'b0, fetch_vld}, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
